adder_checker: RTL and testbench

Synthesizable self-checking response monitor for the lab adder datapath. It consumes operand/result vectors (inA, inB, the adder's W+1-bit out) over a valid/ready handshake. Each vector is checked against an internally computed reference sum, with pass and fail tallies kept. The first mismatching vector is latched for debug readout. It sits downstream of the adder and is the receiving end of the stimulus stream the adder bench drives, so adder checks can run on-board without a simulator.

---
 rtl/adder_checker.sv | 184 ++++++++++++++++++
 tb/tb_adder_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// adder_checker
//   On-board response monitor for the lab adder. Each operand/result vector
//   taken over a valid/ready handshake is registered (stage 1), then compared
//   one cycle later against a full-width reference sum (stage 2). Matching and
//   mismatching vectors are tallied in saturating counters. The first mismatch
//   since reset or clear is latched for debug readout.
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   clear         synchronous soft clear: flush stage 1, zero counters,
//                 drop the latched failure, return to IDLE
//   stop_on_fail  when 1, a stage-2 mismatch halts intake
//   in_valid      vector present on in_a/in_b/in_sum
//   in_ready      checker accepts a vector this cycle (registered state decode)
//   in_a, in_b    operands as applied to the adder (W bits)
//   in_sum        adder output for that pair (W+1 bits)
//   pass_count    matching vectors, saturating
//   fail_count    mismatching vectors, saturating
//   halted        checker is in HALT
//   ff_valid      a first failure is latched
//   ff_a, ff_b    operands of the first failure
//   ff_sum        observed sum of the first failure
//   ff_exp        expected sum of the first failure
module adder_checker #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             stop_on_fail,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_sum,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             halted,
  output logic             ff_valid,
  output logic [W-1:0]     ff_a,
  output logic [W-1:0]     ff_b,
  output logic [W:0]       ff_sum,
  output logic [W:0]       ff_exp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_reg, state_next;

  logic             s1_valid_reg;
  logic [W-1:0]     s1_a_reg;
  logic [W-1:0]     s1_b_reg;
  logic [W:0]       s1_sum_reg;

  logic [CNT_W-1:0] pass_reg;
  logic [CNT_W-1:0] fail_reg;
  logic             ff_valid_reg;
  logic [W-1:0]     ff_a_reg;
  logic [W-1:0]     ff_b_reg;
  logic [W:0]       ff_sum_reg;
  logic [W:0]       ff_exp_reg;

  logic             ready_dec;
  logic             halted_dec;
  logic             accept;
  logic [W:0]       exp_sum;
  logic             match;
  logic             halt_evt;

  // Reference sum is computed one bit wider than the operands so the carry
  // out is compared too.
  assign exp_sum  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
  assign match    = (s1_sum_reg == exp_sum);
  assign halt_evt = s1_valid_reg && !match && stop_on_fail;
  assign accept   = in_valid && ready_dec;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (halt_evt)    state_next = HALT;
          else if (accept) state_next = RUN;
        end
        RUN: begin
          if (halt_evt) state_next = HALT;
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // in_ready depends only on the state register, never on in_valid.
  always_comb begin
    ready_dec  = 1'b1;
    halted_dec = 1'b0;
    if (state_reg == HALT) begin
      ready_dec  = 1'b0;
      halted_dec = 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 1
  // A vector accepted on the halting edge is dropped, as is anything in
  // flight at clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_sum_reg   <= '0;
    end else begin
      s1_valid_reg <= accept && !clear && !halt_evt;
      if (accept) begin
        s1_a_reg   <= in_a;
        s1_b_reg   <= in_b;
        s1_sum_reg <= in_sum;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pass_reg     <= '0;
      fail_reg     <= '0;
      ff_valid_reg <= 1'b0;
      ff_a_reg     <= '0;
      ff_b_reg     <= '0;
      ff_sum_reg   <= '0;
      ff_exp_reg   <= '0;
    end else if (clear) begin
      // Failure data is left in place but marked invalid.
      pass_reg     <= '0;
      fail_reg     <= '0;
      ff_valid_reg <= 1'b0;
    end else if (s1_valid_reg) begin
      if (match) begin
        if (pass_reg != CNT_MAX) pass_reg <= pass_reg + CNT_ONE;
      end else begin
        if (fail_reg != CNT_MAX) fail_reg <= fail_reg + CNT_ONE;
        if (!ff_valid_reg) begin
          ff_valid_reg <= 1'b1;
          ff_a_reg     <= s1_a_reg;
          ff_b_reg     <= s1_b_reg;
          ff_sum_reg   <= s1_sum_reg;
          ff_exp_reg   <= exp_sum;
        end
      end
    end
  end

  assign in_ready   = ready_dec;
  assign halted     = halted_dec;
  assign pass_count = pass_reg;
  assign fail_count = fail_reg;
  assign ff_valid   = ff_valid_reg;
  assign ff_a       = ff_a_reg;
  assign ff_b       = ff_b_reg;
  assign ff_sum     = ff_sum_reg;
  assign ff_exp     = ff_exp_reg;

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker
//   Drives adder_checker (W=32, CNT_W=4 so saturation is reachable) with
//   scenario tasks. Each accepted vector is pushed to a scoreboard queue
//   together with its reference sum; it is popped one edge later, when the
//   checker reports it, and the model counters / first-failure fields are
//   updated and compared against the DUT.
module tb_adder_checker;

  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic             stop_on_fail;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W:0]       in_sum;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             halted;
  logic             ff_valid;
  logic [W-1:0]     ff_a;
  logic [W-1:0]     ff_b;
  logic [W:0]       ff_sum;
  logic [W:0]       ff_exp;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adder_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .stop_on_fail (stop_on_fail),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sum       (in_sum),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .halted       (halted),
    .ff_valid     (ff_valid),
    .ff_a         (ff_a),
    .ff_b         (ff_b),
    .ff_sum       (ff_sum),
    .ff_exp       (ff_exp)
  );

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
    logic [W:0]   e;
  } vec_t;

  vec_t             sb_q[$];
  logic [CNT_W-1:0] m_pass;
  logic [CNT_W-1:0] m_fail;
  logic             m_halt;
  logic             m_ffv;
  logic [W-1:0]     m_ffa;
  logic [W-1:0]     m_ffb;
  logic [W:0]       m_ffs;
  logic [W:0]       m_ffe;

  // One clock: drive inputs, take the edge, advance the model, settle #1.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] s, input logic clr, input logic rst_n,
                       input logic stop);
    vec_t e;
    logic was_halt;
    logic halting;
    in_valid     = v;
    in_a         = a;
    in_b         = b;
    in_sum       = s;
    clear        = clr;
    reset_n      = rst_n;
    stop_on_fail = stop;
    @(posedge clk);
    if (!rst_n) begin
      m_pass = '0; m_fail = '0; m_halt = 1'b0; m_ffv = 1'b0;
      m_ffa = '0; m_ffb = '0; m_ffs = '0; m_ffe = '0;
      sb_q.delete();
    end else if (clr) begin
      m_pass = '0; m_fail = '0; m_halt = 1'b0; m_ffv = 1'b0;
      sb_q.delete();
    end else begin
      was_halt = m_halt;
      halting  = 1'b0;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.s == e.e) begin
          if (m_pass != CMAX) m_pass = m_pass + 1'b1;
        end else begin
          if (m_fail != CMAX) m_fail = m_fail + 1'b1;
          if (!m_ffv) begin
            m_ffv = 1'b1; m_ffa = e.a; m_ffb = e.b; m_ffs = e.s; m_ffe = e.e;
          end
          if (stop) begin
            halting = 1'b1;
            m_halt  = 1'b1;
          end
        end
      end
      if (v && !was_halt && !halting) begin
        e.a = a; e.b = b; e.s = s;
        e.e = {1'b0, a} + {1'b0, b};
        sb_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic stop);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, stop);
  endtask

  task automatic do_clear();
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    cycle(1'b1, 32'd7, 32'd7, 33'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b expected 0", halted); end
    tests_run++; if (pass_count !== '0 || fail_count !== '0) begin tests_failed++; $display("FAIL reset_counts: got pass=%0d fail=%0d expected 0/0", pass_count, fail_count); end
    tests_run++; if (ff_valid !== 1'b0 || ff_a !== '0 || ff_b !== '0 || ff_sum !== '0 || ff_exp !== '0) begin tests_failed++; $display("FAIL reset_ff: got v=%b a=%0h b=%0h s=%0h e=%0h expected all 0", ff_valid, ff_a, ff_b, ff_sum, ff_exp); end
  endtask

  task automatic test_clean_stream();
    logic [W-1:0] ta[3] = '{32'd1, 32'd5, 32'd3};
    logic [W-1:0] tb[3] = '{32'd1, 32'd6, 32'd4};
    logic [W:0]   ts[3] = '{33'd2, 33'd11, 33'd7};
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ta[i], tb[i], ts[i], 1'b0, 1'b1, 1'b0);
      tests_run++; if (pass_count !== m_pass) begin tests_failed++; $display("FAIL clean_latency[%0d]: got pass=%0d expected %0d", i, pass_count, m_pass); end
    end
    idle(2, 1'b0);
    tests_run++; if (pass_count !== 4'd3 || fail_count !== 4'd0) begin tests_failed++; $display("FAIL clean_counts: got pass=%0d fail=%0d expected 3/0", pass_count, fail_count); end
    tests_run++; if (ff_valid !== 1'b0) begin tests_failed++; $display("FAIL clean_ff_valid: got %b expected 0", ff_valid); end
  endtask

  task automatic test_carry();
    do_clear();
    cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 33'h0_0000_0000, 1'b0, 1'b1, 1'b0);
    tests_run++; if (pass_count !== 4'd1 || fail_count !== 4'd0) begin tests_failed++; $display("FAIL carry_pass: got pass=%0d fail=%0d expected 1/0", pass_count, fail_count); end
    idle(2, 1'b0);
    tests_run++; if (fail_count !== 4'd1) begin tests_failed++; $display("FAIL carry_fail_count: got %0d expected 1", fail_count); end
    tests_run++; if (ff_valid !== 1'b1 || ff_exp !== 33'h1_0000_0000 || ff_sum !== 33'h0) begin tests_failed++; $display("FAIL carry_ff: got v=%b exp=%0h sum=%0h expected 1/100000000/0", ff_valid, ff_exp, ff_sum); end
  endtask

  task automatic test_first_fail();
    logic [W-1:0] ta[3] = '{32'd2, 32'd3, 32'd1};
    logic [W-1:0] tb[3] = '{32'd2, 32'd3, 32'd8};
    logic [W:0]   ts[3] = '{33'd5, 33'd7, 33'd9};
    do_clear();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ta[i], tb[i], ts[i], 1'b0, 1'b1, 1'b0);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL ff_no_stall[%0d]: got in_ready=%b expected 1", i, in_ready); end
    end
    idle(2, 1'b0);
    tests_run++; if (pass_count !== 4'd1 || fail_count !== 4'd2) begin tests_failed++; $display("FAIL ff_counts: got pass=%0d fail=%0d expected 1/2", pass_count, fail_count); end
    tests_run++; if (ff_a !== 32'd2 || ff_b !== 32'd2 || ff_sum !== 33'd5 || ff_exp !== 33'd4) begin tests_failed++; $display("FAIL ff_hold: got a=%0d b=%0d s=%0d e=%0d expected 2/2/5/4", ff_a, ff_b, ff_sum, ff_exp); end
  endtask

  task automatic test_halt();
    do_clear();
    cycle(1'b1, 32'd1, 32'd2, 33'd4, 1'b0, 1'b1, 1'b1);
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_early: got halted=%b expected 0", halted); end
    cycle(1'b1, 32'd3, 32'd4, 33'd7, 1'b0, 1'b1, 1'b1);
    tests_run++; if (halted !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL halt_entry: got halted=%b in_ready=%b expected 1/0", halted, in_ready); end
    cycle(1'b1, 32'd3, 32'd4, 33'd7, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    tests_run++; if (pass_count !== 4'd0 || fail_count !== 4'd1) begin tests_failed++; $display("FAIL halt_counts: got pass=%0d fail=%0d expected 0/1", pass_count, fail_count); end
    tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_persist: got %b expected 1", halted); end
    do_clear();
    tests_run++; if (halted !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL halt_clear_state: got halted=%b in_ready=%b expected 0/1", halted, in_ready); end
    tests_run++; if (pass_count !== '0 || fail_count !== '0 || ff_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_clear_regs: got pass=%0d fail=%0d ffv=%b expected 0/0/0", pass_count, fail_count, ff_valid); end
  endtask

  task automatic test_clear_reset();
    do_clear();
    cycle(1'b1, 32'd1, 32'd1, 33'd2, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);
    tests_run++; if (pass_count !== 4'd0) begin tests_failed++; $display("FAIL clear_vs_accept: got pass=%0d expected 0", pass_count); end
    cycle(1'b1, 32'd2, 32'd2, 33'd4, 1'b0, 1'b1, 1'b0);
    do_clear();
    idle(1, 1'b0);
    tests_run++; if (pass_count !== 4'd0) begin tests_failed++; $display("FAIL clear_flush_s1: got pass=%0d expected 0", pass_count); end
    cycle(1'b1, 32'd3, 32'd3, 33'd5, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    tests_run++; if (pass_count !== '0 || fail_count !== '0 || ff_valid !== 1'b0 || ff_a !== '0 || halted !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_vs_clear: got pass=%0d fail=%0d ffv=%b ffa=%0h halted=%b rdy=%b expected reset state", pass_count, fail_count, ff_valid, ff_a, halted, in_ready); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] a;
    logic [W-1:0] b;
    do_clear();
    for (int i = 0; i < 17; i++) begin
      a = $urandom; b = $urandom;
      cycle(1'b1, a, b, {1'b0, a} + {1'b0, b}, 1'b0, 1'b1, 1'b0);
    end
    cycle(1'b1, 32'd9, 32'd9, 33'd17, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    tests_run++; if (pass_count !== 4'd15) begin tests_failed++; $display("FAIL sat_pass: got %0d expected 15", pass_count); end
    tests_run++; if (fail_count !== 4'd1) begin tests_failed++; $display("FAIL sat_fail: got %0d expected 1", fail_count); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
    logic         v;
    do_clear();
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      s = {1'b0, a} + {1'b0, b};
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, W)] ^= 1'b1;
      v = ($urandom_range(0, 4) != 0);
      cycle(v, a, b, s, 1'b0, 1'b1, 1'b0);
      tests_run++; if (pass_count !== m_pass || fail_count !== m_fail) begin tests_failed++; $display("FAIL b2b_counts[%0d]: got pass=%0d fail=%0d expected %0d/%0d", i, pass_count, fail_count, m_pass, m_fail); end
    end
    idle(2, 1'b0);
    tests_run++; if (ff_valid !== m_ffv || (m_ffv && (ff_a !== m_ffa || ff_b !== m_ffb || ff_sum !== m_ffs || ff_exp !== m_ffe))) begin tests_failed++; $display("FAIL b2b_ff: got v=%b a=%0h b=%0h s=%0h e=%0h expected v=%b a=%0h b=%0h s=%0h e=%0h", ff_valid, ff_a, ff_b, ff_sum, ff_exp, m_ffv, m_ffa, m_ffb, m_ffs, m_ffe); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; stop_on_fail = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
    test_reset();
    test_clean_stream();
    test_carry();
    test_first_fail();
    test_halt();
    test_clear_reset();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
